// File: rtl/lane_evt_pkg.sv
// Shared defaults and helpers for the lane debounce / event FIFO slice.
// Lane index width is derived from the lane count.
package lane_evt_pkg;

  localparam int DEB_CYCLES_DEF = 4;
  localparam int DEPTH_DEF      = 4;

  function automatic int lane_w(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/lane_debounce.sv
// One lane: 2-flop synchroniser followed by a run-length debouncer.
// chg is high on the cycle lvl is about to take the new level.
module lane_debounce
  import lane_evt_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic lvl,
  output logic chg
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          meta;
  logic          s;
  logic [CW-1:0] cnt;

  assign chg = (s != lvl) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      s    <= 1'b0;
    end else begin
      meta <= d;
      s    <= meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      lvl <= 1'b0;
    end else if (s == lvl) begin
      cnt <= '0;
    end else if (chg) begin
      lvl <= s;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lane_debounce_fifo.sv
// Per-lane debounce, round-robin change arbiter and show-ahead
// event FIFO carrying {lane, level} to the downstream lane logic.
module lane_debounce_fifo
  import lane_evt_pkg::*;
#(
  parameter  int P          = 1,
  parameter  int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter  int DEPTH      = DEPTH_DEF,
  localparam int LW         = lane_w(P)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [P-1:0]  d,
  output logic [P-1:0]  lvl,
  output logic          evt_valid,
  input  logic          evt_ready,
  output logic [LW-1:0] evt_lane,
  output logic          evt_level,
  output logic          overflow,
  input  logic          clr_overflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  typedef struct packed {
    logic [LW-1:0] lane;
    logic          level;
  } evt_t;

  logic [P-1:0]    chg;
  logic [P-1:0]    pend;
  logic [P-1:0]    pend_nxt;
  logic [LW-1:0]   last;
  logic [LW-1:0]   gnt_lane;
  logic            gnt;
  logic            pop;
  logic            coal;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CNTW-1:0] count;
  evt_t            mem [DEPTH];

  for (genvar i = 0; i < P; i++) begin : g_lane
    lane_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (d[i]),
      .lvl  (lvl[i]),
      .chg  (chg[i])
    );
  end

  function automatic logic [LW-1:0] rr_idx(
    input logic [LW-1:0] base,
    input int            k
  );
    return LW'((int'(base) + 1 + k) % P);
  endfunction

  // Full is judged on the registered count, so a pop never frees a slot early.
  always_comb begin
    gnt      = 1'b0;
    gnt_lane = '0;
    if (count < FULL_CNT) begin
      for (int k = 0; k < P; k++) begin
        if (!gnt && pend[rr_idx(last, k)]) begin
          gnt      = 1'b1;
          gnt_lane = rr_idx(last, k);
        end
      end
    end
  end

  // A fresh change beats the grant clear; it only counts as lost if not granted.
  always_comb begin
    pend_nxt = pend;
    coal     = 1'b0;
    for (int i = 0; i < P; i++) begin
      if (chg[i]) begin
        pend_nxt[i] = 1'b1;
        if (pend[i] && !(gnt && gnt_lane == LW'(i))) begin
          coal = 1'b1;
        end
      end else if (gnt && gnt_lane == LW'(i)) begin
        pend_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      last     <= LW'(P - 1);
      overflow <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (gnt) begin
        last <= gnt_lane;
      end
      if (coal) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  assign evt_valid = (count != '0);
  assign pop       = evt_valid && evt_ready;
  assign evt_lane  = mem[rd_ptr].lane;
  assign evt_level = mem[rd_ptr].level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        mem[j] <= '0;
      end
    end else begin
      if (gnt) begin
        mem[wr_ptr] <= evt_t'{lane: gnt_lane, level: lvl[gnt_lane]};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({gnt, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_debounce_fifo.sv
// Scenario and randomized bench for lane_debounce_fifo (P=4, DEB=4,
// DEPTH=4) against a queue-based behavioural model.
module tb_lane_debounce_fifo;

  localparam int P     = 4;
  localparam int DEB   = 4;
  localparam int DEPTH = 4;
  localparam int LW    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [P-1:0]  d = '0;
  logic [P-1:0]  lvl;
  logic          evt_valid;
  logic          evt_ready = 1'b0;
  logic [LW-1:0] evt_lane;
  logic          evt_level;
  logic          overflow;
  logic          clr_overflow = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  lane_debounce_fifo #(
    .P(P),
    .DEB_CYCLES(DEB),
    .DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .d           (d),
    .lvl         (lvl),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_lane    (evt_lane),
    .evt_level   (evt_level),
    .overflow    (overflow),
    .clr_overflow(clr_overflow)
  );

  // behavioural model: s is d two edges late; a level is accepted once
  // s has disagreed with it on DEB consecutive edges
  logic [P-1:0] m_s1, m_s, m_lvl, m_pend;
  int           m_run [P];
  int           m_last;
  bit           m_ovf;
  logic [2:0]   m_q [$];
  logic [2:0]   dut_log [$];

  task automatic model_reset();
    m_s1 = '0; m_s = '0; m_lvl = '0; m_pend = '0;
    foreach (m_run[i]) m_run[i] = 0;
    m_last = P - 1;
    m_ovf = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step();
    logic [P-1:0] nlvl, chg;
    bit do_pop, coal;
    int g;
    logic [2:0] ev;
    if (!rst_n) begin
      model_reset();
      return;
    end
    nlvl = m_lvl; chg = '0; coal = 1'b0; ev = '0; g = -1;
    do_pop = (m_q.size() > 0) && evt_ready;
    if (m_q.size() < DEPTH) begin
      for (int k = 0; k < P; k++) begin
        if (g < 0 && m_pend[(m_last + 1 + k) % P]) g = (m_last + 1 + k) % P;
      end
    end
    if (g >= 0) ev = {2'(g), m_lvl[g]};
    for (int i = 0; i < P; i++) begin
      if (m_s[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          nlvl[i] = m_s[i];
          chg[i] = 1'b1;
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    for (int i = 0; i < P; i++) begin
      if (chg[i] && m_pend[i] && g != i) coal = 1'b1;
      if (chg[i]) m_pend[i] = 1'b1;
      else if (g == i) m_pend[i] = 1'b0;
    end
    if (coal) m_ovf = 1'b1;
    else if (clr_overflow) m_ovf = 1'b0;
    if (do_pop) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(ev);
      m_last = g;
    end
    m_lvl = nlvl;
    m_s = m_s1;
    m_s1 = d;
  endtask

  function automatic logic [8:0] model_vec();
    logic [2:0] h;
    h = '0;
    if (m_q.size() != 0) h = m_q[0];
    return {m_lvl, m_q.size() != 0, h, m_ovf};
  endfunction

  function automatic logic [8:0] dut_vec();
    logic [2:0] h;
    h = evt_valid ? {evt_lane, evt_level} : 3'b000;
    return {lvl, evt_valid, h, overflow};
  endfunction

  function automatic logic [31:0] pack_q(input logic [2:0] q[$]);
    logic [31:0] r;
    r = '0;
    r[31:24] = 8'(q.size());
    for (int i = 0; i < q.size() && i < 8; i++) r[3*i +: 3] = q[i];
    return r;
  endfunction

  task automatic tick();
    if (evt_valid && evt_ready) dut_log.push_back({evt_lane, evt_level});
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    d = '0; evt_ready = 1'b0; clr_overflow = 1'b0;
    rst_n = 1'b0;
    model_reset();
    run(3);
    rst_n = 1'b1;
    dut_log.delete();
  endtask

  task automatic test_reset();
    d = '0; evt_ready = 1'b0; clr_overflow = 1'b0;
    rst_n = 1'b0;
    model_reset();
    run(3);
    total_cnt++;
    if ({evt_valid, evt_lane, evt_level} !== 4'b0000)
      $display("FAIL reset_evt: got %b want 0000", {evt_valid, evt_lane, evt_level});
    else pass_cnt++;
    total_cnt++;
    if ({lvl, overflow} !== 5'b00000)
      $display("FAIL reset_lvl_ovf: got %b want 00000", {lvl, overflow});
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_clean_rise();
    int first_v, nv;
    logic [2:0] exp[$];
    first_v = -1; nv = 0;
    do_reset();
    evt_ready = 1'b1;
    run(10);
    d[2] = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      total_cnt++;
      if (dut_vec() !== model_vec())
        $display("FAIL rise_model k=%0d: got %h want %h", k, dut_vec(), model_vec());
      else pass_cnt++;
      if (evt_valid) begin
        if (first_v < 0) first_v = k;
        nv++;
      end
    end
    total_cnt++;
    if (first_v !== 6 || nv !== 1)
      $display("FAIL rise_latency: got first=%0d n=%0d want first=6 n=1", first_v, nv);
    else pass_cnt++;
    exp = '{3'b101};
    total_cnt++;
    if (pack_q(dut_log) !== pack_q(exp))
      $display("FAIL rise_events: got %h want %h", pack_q(dut_log), pack_q(exp));
    else pass_cnt++;
    total_cnt++;
    if (lvl[2] !== 1'b1) $display("FAIL rise_lvl: got %b want 1", lvl[2]);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    do_reset();
    evt_ready = 1'b1;
    d[0] = 1'b1;
    run(3);
    d[0] = 1'b0;
    for (int k = 0; k < 14; k++) begin
      tick();
      total_cnt++;
      if (dut_vec() !== model_vec())
        $display("FAIL glitch_model k=%0d: got %h want %h", k, dut_vec(), model_vec());
      else pass_cnt++;
    end
    total_cnt++;
    if (dut_log.size() != 0 || lvl[0] !== 1'b0 || overflow !== 1'b0)
      $display("FAIL glitch: got n=%0d lvl0=%b ovf=%b want 0 0 0",
               dut_log.size(), lvl[0], overflow);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    int first_v, last_v, nv;
    logic [2:0] exp[$];
    first_v = -1; last_v = -1; nv = 0;
    do_reset();
    evt_ready = 1'b1;
    d = 4'b1011;
    for (int k = 0; k < 16; k++) begin
      tick();
      total_cnt++;
      if (dut_vec() !== model_vec())
        $display("FAIL simul_model k=%0d: got %h want %h", k, dut_vec(), model_vec());
      else pass_cnt++;
      if (evt_valid) begin
        if (first_v < 0) first_v = k;
        last_v = k;
        nv++;
      end
    end
    exp = '{3'b001, 3'b011, 3'b111};
    total_cnt++;
    if (pack_q(dut_log) !== pack_q(exp))
      $display("FAIL simul_order: got %h want %h", pack_q(dut_log), pack_q(exp));
    else pass_cnt++;
    total_cnt++;
    if (nv != 3 || last_v - first_v != 2)
      $display("FAIL simul_back_to_back: got n=%0d span=%0d want 3 2", nv, last_v - first_v);
    else pass_cnt++;
  endtask

  task automatic test_back_pressure();
    logic [2:0] exp[$];
    do_reset();
    d = 4'hF;
    for (int k = 0; k < 24; k++) begin
      if (k == 12) d[0] = 1'b0;
      tick();
      total_cnt++;
      if (dut_vec() !== model_vec())
        $display("FAIL bp_model k=%0d: got %h want %h", k, dut_vec(), model_vec());
      else pass_cnt++;
    end
    total_cnt++;
    if ({evt_valid, evt_lane, evt_level, overflow, lvl[0]} !== 6'b100100)
      $display("FAIL bp_held: got %b want 100100",
               {evt_valid, evt_lane, evt_level, overflow, lvl[0]});
    else pass_cnt++;
    evt_ready = 1'b1;
    run(12);
    exp = '{3'b001, 3'b011, 3'b101, 3'b111, 3'b000};
    total_cnt++;
    if (pack_q(dut_log) !== pack_q(exp) || overflow !== 1'b0)
      $display("FAIL bp_drain: got %h ovf=%b want %h ovf=0",
               pack_q(dut_log), overflow, pack_q(exp));
    else pass_cnt++;
  endtask

  task automatic test_coalesce();
    logic [2:0] exp[$];
    do_reset();
    d = 4'hF;
    for (int k = 0; k < 36; k++) begin
      if (k == 12) d[1] = 1'b0;
      if (k == 24) d[1] = 1'b1;
      tick();
      total_cnt++;
      if (dut_vec() !== model_vec())
        $display("FAIL coal_model k=%0d: got %h want %h", k, dut_vec(), model_vec());
      else pass_cnt++;
    end
    total_cnt++;
    if (overflow !== 1'b1) $display("FAIL coal_set: got %b want 1", overflow);
    else pass_cnt++;
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL coal_clear: got %b want 0", overflow);
    else pass_cnt++;
    evt_ready = 1'b1;
    run(12);
    exp = '{3'b001, 3'b011, 3'b101, 3'b111, 3'b011};
    total_cnt++;
    if (pack_q(dut_log) !== pack_q(exp))
      $display("FAIL coal_events: got %h want %h", pack_q(dut_log), pack_q(exp));
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp[$];
    do_reset();
    d = 4'b0011;
    run(9);
    total_cnt++;
    if (evt_valid !== 1'b1) $display("FAIL mid_queued: got %b want 1", evt_valid);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total_cnt++;
    if ({evt_valid, lvl, overflow} !== 6'b000000)
      $display("FAIL mid_async_reset: got %b want 000000", {evt_valid, lvl, overflow});
    else pass_cnt++;
    d = 4'b0101;
    run(2);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    dut_log.delete();
    for (int k = 0; k < 16; k++) begin
      tick();
      total_cnt++;
      if (dut_vec() !== model_vec())
        $display("FAIL mid_model k=%0d: got %h want %h", k, dut_vec(), model_vec());
      else pass_cnt++;
    end
    exp = '{3'b001, 3'b101};
    total_cnt++;
    if (pack_q(dut_log) !== pack_q(exp))
      $display("FAIL mid_events: got %h want %h", pack_q(dut_log), pack_q(exp));
    else pass_cnt++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1200; c++) begin
      if ($urandom_range(0, 9) == 0) d[$urandom_range(0, P-1)] ^= 1'b1;
      if (c % 300 < 150) evt_ready = ($urandom_range(0, 7) == 0);
      else evt_ready = ($urandom_range(0, 3) != 0);
      clr_overflow = ($urandom_range(0, 39) == 0);
      tick();
      total_cnt++;
      if (dut_vec() !== model_vec())
        $display("FAIL random_model c=%0d: got %h want %h", c, dut_vec(), model_vec());
      else pass_cnt++;
    end
    clr_overflow = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_rise();
    test_glitch();
    test_simultaneous();
    test_back_pressure();
    test_coalesce();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/lane_debounce_fifo.md
# lane_debounce_fifo

Upstream conditioning stage for the generate-for per-lane logic: takes `P` raw asynchronous lane inputs, synchronises and debounces each lane independently, and turns every debounced level change into a `{lane, level}` event. Events are queued in a small FIFO with a valid/ready output. The downstream lane logic consumes either the debounced levels (`lvl`) or the event stream.

## Interface
- `P`, 1: number of lanes, ≥1.
- `DEB_CYCLES`, 4: consecutive cycles of disagreement required to accept a new level, ≥1.
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `LW`, derived, `P>1 ? $clog2(P) : 1`: lane index width.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `d`  in  P  raw lane inputs, asynchronous to `clk`.
- `lvl`  out  P  debounced stable level per lane.
- `evt_valid`  out  1  FIFO head valid.
- `evt_ready`  in  1  consumer accepts head.
- `evt_lane`  out  LW  lane index of head event.
- `evt_level`  out  1  new level of head event.
- `overflow`  out  1  sticky: an event was coalesced (lost).
- `clr_overflow`  in  1  synchronous clear of `overflow`.

## Operation
- Reset (async, `rst_n`=0): all synchronisers, `lvl`, counters, pending bits and FIFO pointers clear immediately.
  - `evt_valid`=0, `evt_lane`=0, `evt_level`=0, `overflow`=0.
  - Round-robin pointer is set so that lane 0 has first priority.
- Per lane i:
  - `d[i]` passes through a 2-flop synchroniser to give `s[i]`.
  - Counter width is `$clog2(DEB_CYCLES+1)`.
  - If `s[i]==lvl[i]`: counter is cleared.
  - Otherwise the counter increments. On the cycle where the counter equals `DEB_CYCLES-1` and `s[i]` still differs: `lvl[i]<=s[i]`, counter cleared, `pend[i]` set.
- Coalescing: if `lvl[i]` changes while `pend[i]` is already 1, `pend[i]` stays 1 and `overflow` is set. The reported level is `lvl[i]` at grant time.
- Arbiter:
  - Each cycle where any `pend` is set and the FIFO count is below `DEPTH` at cycle start, grant exactly one lane.
  - Selection is the first pending lane at or after (last granted + 1), modulo P.
  - Write `{i, lvl[i]}` to the FIFO and clear `pend[i]`.
  - If the same lane changes level in the grant cycle, the set wins: `pend[i]` stays 1 and no overflow is flagged.
- FIFO (show-ahead):
  - `evt_valid` = not empty; head fields are driven directly.
  - Pop on `evt_valid && evt_ready`.
  - Push and pop in the same cycle are both honoured.
  - A full FIFO blocks the push even when a pop happens in the same cycle; full is evaluated on the registered count.
  - Pointers wrap modulo `DEPTH`; the count register is `$clog2(DEPTH)+1` bits wide.
- `overflow`: set on coalesce, cleared by `clr_overflow`; set wins over clear.
- A lane held at 1 through reset release produces a level-1 event after normal latency, because `lvl` resets to 0.

## Timing
- Input change sampled at edge 0 gives `s` updated after edge 1.
- `lvl` and `pend` update at edge `DEB_CYCLES+1`.
- The FIFO write happens at edge `DEB_CYCLES+2` when the lane wins arbitration, so `evt_valid` rises `DEB_CYCLES+2` cycles after the first sampling edge.
- An input pulse shorter than `DEB_CYCLES` cycles at `s` produces no event.
- Arbiter throughput is one event per cycle. With all P lanes pending, each lane is served within P grant cycles.
- `evt_*` are stable while `evt_valid && !evt_ready`.
- All outputs are registered except `evt_valid`, `evt_lane` and `evt_level`, which are FIFO-storage reads.

## Structure
- Package `lane_evt_pkg`:
  - function `lane_w(P)` returning LW;
  - localparam defaults for `DEB_CYCLES` and `DEPTH`.
- The event struct stays in the module because its width depends on P.
- Sub-module `lane_debounce` (synchroniser, counter, `lvl`, change strobe) is instantiated P times with a generate-for.
- Arbiter and FIFO are inline in the top.

## Test plan
Configuration: P=4, DEB_CYCLES=4, DEPTH=4 unless stated.
1. Clean rise: `d[2]` 0→1 at cycle 10, `evt_ready`=1 → exactly one event, lane=2 and level=1, with `evt_valid` high for one cycle starting 6 cycles after the first sampling edge; `lvl[2]`=1.
2. Glitch reject: `d[0]` high for 3 cycles then low → no event; `lvl[0]` stays 0; `overflow`=0.
3. Simultaneous: `d[0]`, `d[1]`, `d[3]` rise together → events for lanes 0, 1, 3 on three consecutive cycles in that order.
4. Back-pressure: `evt_ready`=0 while lanes 0–3 rise, then lane 0 falls → 4 entries queued (lanes 0,1,2,3) and lane 0's fall held pending; release ready → 5th event lane=0 level=0 delivered; `overflow`=0.
5. Coalesce: with the FIFO full and lane 1 pending, toggle `d[1]` again → `overflow`=1; assert `clr_overflow` for 1 cycle → `overflow`=0.
6. Reset mid-stream: 2 entries queued, assert `rst_n`=0 → `evt_valid`=0 immediately. Release with `d`=4'b0101 → events lane 0 then lane 2, both level=1.
